// File: rtl/microcontroller_ws.sv
// Multi-cycle N-bit microcontroller with 16-bit instructions, a req/ready memory
// handshake with unlimited wait states, HALT, and PC-relative branches.
module microcontroller_ws #(
   parameter int           N        = 16,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] din,
   input  logic         ready,
   output logic         req,
   output logic         rw,
   output logic [N-1:0] addr,
   output logic [N-1:0] dout,
   output logic [2:0]   flags,
   output logic         halted
);

   typedef enum logic [2:0] {
      S_RST,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_NOT  = 4'h5,
      OP_MOV  = 4'h6,
      OP_NOP  = 4'h7,
      OP_LD   = 4'h8,
      OP_ST   = 4'h9,
      OP_LDI  = 4'hA,
      OP_HALT = 4'hB,
      OP_BRZ  = 4'hC,
      OP_BRN  = 4'hD,
      OP_BRO  = 4'hE,
      OP_BRA  = 4'hF
   } opcode_t;

   state_t       state;
   logic [N-1:0] pc;
   logic [N-1:0] ia;
   logic [15:0]  ir;
   logic [N-1:0] regs [8];

   opcode_t      op;
   logic [2:0]   rd, ra, rb;
   logic [N-1:0] a, b;
   logic [N-1:0] imm, offset, target, next_fetch;
   logic [N-1:0] alu_res;
   logic         alu_ovf;
   logic         upd_flags;
   logic         wr_reg;
   logic         taken;
   logic [2:0]   new_flags;

   assign op     = opcode_t'(ir[15:12]);
   assign rd     = ir[11:9];
   assign ra     = ir[8:6];
   assign rb     = ir[5:3];
   assign a      = regs[ra];
   assign b      = regs[rb];
   assign imm    = {{(N-9){ir[8]}}, ir[8:0]};
   assign offset = {{(N-12){ir[11]}}, ir[11:0]};
   assign target = ia + offset;

   // Decode/execute of the instruction held in IR; only consumed in EXEC.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      alu_res   = '0;
      alu_ovf   = 1'b0;
      upd_flags = 1'b0;
      wr_reg    = 1'b0;
      taken     = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res   = a + b;
            alu_ovf   = (a[N-1] == b[N-1]) && (alu_res[N-1] != a[N-1]);
            upd_flags = 1'b1;
            wr_reg    = 1'b1;
         end
         OP_SUB: begin
            alu_res   = a - b;
            alu_ovf   = (a[N-1] != b[N-1]) && (alu_res[N-1] != a[N-1]);
            upd_flags = 1'b1;
            wr_reg    = 1'b1;
         end
         OP_AND: begin
            alu_res   = a & b;
            upd_flags = 1'b1;
            wr_reg    = 1'b1;
         end
         OP_OR: begin
            alu_res   = a | b;
            upd_flags = 1'b1;
            wr_reg    = 1'b1;
         end
         OP_XOR: begin
            alu_res   = a ^ b;
            upd_flags = 1'b1;
            wr_reg    = 1'b1;
         end
         OP_NOT: begin
            alu_res   = ~a;
            upd_flags = 1'b1;
            wr_reg    = 1'b1;
         end
         OP_MOV: begin
            alu_res   = a;
            upd_flags = 1'b1;
            wr_reg    = 1'b1;
         end
         OP_LDI: begin
            alu_res = imm;
            wr_reg  = 1'b1;
         end
         OP_BRZ:  taken = flags[2];
         OP_BRN:  taken = flags[1];
         OP_BRO:  taken = flags[0];
         OP_BRA:  taken = 1'b1;
         default: ;
      endcase
      new_flags  = {(alu_res == '0), alu_res[N-1], alu_ovf};
      next_fetch = taken ? target : pc;
   end

   // NOTE: all state, including the outputs, uses non-blocking assignments so
   // every register samples the pre-edge values (sources read before write).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_RST;
         pc     <= RESET_PC;
         ia     <= '0;
         ir     <= '0;
         flags  <= '0;
         req    <= 1'b0;
         rw     <= 1'b1;
         addr   <= '0;
         dout   <= '0;
         halted <= 1'b0;
         // NOTE: the register file is small and must read as zero after reset,
         // so it is reset here rather than left as an uninitialised RAM.
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_RST: begin
               state <= S_FETCH;
               req   <= 1'b1;
               rw    <= 1'b1;
               addr  <= pc;
               dout  <= '0;
            end
            S_FETCH: begin
               if (ready) begin
                  ir    <= din[15:0];
                  ia    <= pc;
                  pc    <= pc + N'(1);
                  req   <= 1'b0;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_LD: begin
                     state <= S_MEM;
                     req   <= 1'b1;
                     rw    <= 1'b1;
                     addr  <= a;
                  end
                  OP_ST: begin
                     state <= S_MEM;
                     req   <= 1'b1;
                     rw    <= 1'b0;
                     addr  <= a;
                     dout  <= b;
                  end
                  OP_HALT: begin
                     state  <= S_HALT;
                     req    <= 1'b0;
                     halted <= 1'b1;
                  end
                  default: begin
                     if (wr_reg)    regs[rd] <= alu_res;
                     if (upd_flags) flags    <= new_flags;
                     if (taken)     pc       <= target;
                     state <= S_FETCH;
                     req   <= 1'b1;
                     rw    <= 1'b1;
                     addr  <= next_fetch;
                  end
               endcase
            end
            S_MEM: begin
               if (ready) begin
                  if (rw) regs[rd] <= din;
                  state <= S_FETCH;
                  req   <= 1'b1;
                  rw    <= 1'b1;
                  addr  <= pc;
                  dout  <= '0;
               end
            end
            S_HALT: begin
               req    <= 1'b0;
               halted <= 1'b1;
            end
            default: state <= S_RST;
         endcase
      end
   end

endmodule
